// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - fetch-to-decode pipeline register with warmup, freeze-on-fault and event counters
module pipe_stage_reg #(
  parameter int         VAL_W  = 64,
  parameter int         WARMUP = 1,
  parameter logic [7:0] NOP_OP = 8'h10,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       f_stat,
  input  logic [7:0]       f_opcode,
  input  logic [7:0]       f_rArB,
  input  logic [VAL_W-1:0] f_valC,
  input  logic [VAL_W-1:0] f_valP,
  input  logic             stall,
  input  logic             bubble,
  output logic [1:0]       D_stat,
  output logic [7:0]       D_opcode,
  output logic [7:0]       D_rArB,
  output logic [VAL_W-1:0] D_valC,
  output logic [VAL_W-1:0] D_valP,
  output logic             D_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  // With no warmup requested the register is live straight out of reset.
  localparam state_t RESET_ST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
  localparam int     WC_W     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  state_t          cur_st;
  state_t          nxt_st;
  logic [WC_W-1:0] wcnt;
  logic            active;
  logic            do_stall;
  logic            do_bubble;
  logic            do_load;
  logic            fault;

  // The edge on which the warmup counter reads zero already behaves as a RUN edge.
  assign active    = (cur_st == ST_RUN) || ((cur_st == ST_WARMUP) && (wcnt == '0));
  assign do_stall  = active && stall;
  assign do_bubble = active && !stall && bubble;
  assign do_load   = active && !stall && !bubble;
  assign fault     = do_load && (f_stat != 2'b00);
  assign state     = cur_st;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= RESET_ST;
    else        cur_st <= nxt_st;
  end

  // Next-state logic: a faulting load freezes the stage until reset.
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_WARMUP: if (wcnt == '0) nxt_st = fault ? ST_FROZEN : ST_RUN;
      ST_RUN:    if (fault) nxt_st = ST_FROZEN;
      ST_FROZEN: nxt_st = ST_FROZEN;
      default:   nxt_st = RESET_ST;
    endcase
  end

  // Warmup down-counter, only moves while still warming up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= WC_W'(WARMUP);
    end else if ((cur_st == ST_WARMUP) && (wcnt != '0)) begin
      wcnt <= wcnt - WC_W'(1);
    end
  end

  // Pipeline fields: stall holds, bubble inserts a NOP, otherwise capture upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_stat   <= 2'b00;
      D_opcode <= NOP_OP;
      D_rArB   <= 8'hFF;
      D_valC   <= '0;
      D_valP   <= '0;
      D_valid  <= 1'b0;
    end else if (do_bubble) begin
      D_stat   <= 2'b00;
      D_opcode <= NOP_OP;
      D_rArB   <= 8'hFF;
      D_valC   <= '0;
      D_valP   <= '0;
      D_valid  <= 1'b0;
    end else if (do_load) begin
      D_stat   <= f_stat;
      D_opcode <= f_opcode;
      D_rArB   <= f_rArB;
      D_valC   <= f_valC;
      D_valP   <= f_valP;
      D_valid  <= 1'b1;
    end
  end

  // Saturating event counters; stall wins when both requests arrive together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (do_stall && (stall_cnt != '1))   stall_cnt  <= stall_cnt + CNT_W'(1);
      if (do_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst0_n;
  logic        rst1_n;
  logic [1:0]  f_stat;
  logic [7:0]  f_opcode;
  logic [7:0]  f_rArB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        stall;
  logic        bubble;

  logic [1:0]  d0_stat, d1_stat;
  logic [7:0]  d0_opcode, d1_opcode;
  logic [7:0]  d0_rArB, d1_rArB;
  logic [63:0] d0_valC, d1_valC;
  logic [63:0] d0_valP, d1_valP;
  logic        d0_valid, d1_valid;
  logic [1:0]  st0, st1;
  logic [15:0] scnt0, bcnt0;
  logic [1:0]  scnt1, bcnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u0 (
    .clk(clk), .rst_n(rst0_n), .f_stat(f_stat), .f_opcode(f_opcode), .f_rArB(f_rArB),
    .f_valC(f_valC), .f_valP(f_valP), .stall(stall), .bubble(bubble),
    .D_stat(d0_stat), .D_opcode(d0_opcode), .D_rArB(d0_rArB), .D_valC(d0_valC),
    .D_valP(d0_valP), .D_valid(d0_valid), .state(st0), .stall_cnt(scnt0), .bubble_cnt(bcnt0)
  );

  pipe_stage_reg #(.VAL_W(64), .WARMUP(0), .NOP_OP(8'h10), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst1_n), .f_stat(f_stat), .f_opcode(f_opcode), .f_rArB(f_rArB),
    .f_valC(f_valC), .f_valP(f_valP), .stall(stall), .bubble(bubble),
    .D_stat(d1_stat), .D_opcode(d1_opcode), .D_rArB(d1_rArB), .D_valC(d1_valC),
    .D_valP(d1_valP), .D_valid(d1_valid), .state(st1), .stall_cnt(scnt1), .bubble_cnt(bcnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    f_stat = 2'b00; f_opcode = 8'h30; f_rArB = 8'h12; f_valC = 64'd5; f_valP = 64'd10;
    stall = 1'b0; bubble = 1'b0;
    step();
    chk("rst_opcode", d0_opcode, 8'h10);
    chk("rst_rArB", d0_rArB, 8'hFF);
    chk("rst_valid", d0_valid, 1'b0);
    chk("rst_state", st0, 2'b00);
    chk("rst_scnt", scnt0, 0);
    chk("rst_state_w0", st1, 2'b01);

    rst0_n = 1'b1;
    step();
    chk("warm_e1_state", st0, 2'b00);
    chk("warm_e1_valid", d0_valid, 1'b0);
    chk("warm_e1_opcode", d0_opcode, 8'h10);
    step();
    chk("warm_e2_opcode", d0_opcode, 8'h30);
    chk("warm_e2_valC", d0_valC, 64'd5);
    chk("warm_e2_valid", d0_valid, 1'b1);
    chk("warm_e2_state", st0, 2'b01);

    f_opcode = 8'h60;
    step();
    chk("load_60", d0_opcode, 8'h60);
    stall = 1'b1; f_opcode = 8'h70;
    step(); step(); step();
    chk("stall_hold_op", d0_opcode, 8'h60);
    chk("stall_hold_valid", d0_valid, 1'b1);
    chk("stall_cnt3", scnt0, 16'd3);

    bubble = 1'b1;
    step();
    chk("sb_hold_op", d0_opcode, 8'h60);
    chk("sb_scnt", scnt0, 16'd4);
    chk("sb_bcnt", bcnt0, 16'd0);
    stall = 1'b0;
    step();
    chk("bub_op", d0_opcode, 8'h10);
    chk("bub_valid", d0_valid, 1'b0);
    chk("bub_rArB", d0_rArB, 8'hFF);
    chk("bub_valC", d0_valC, 64'd0);
    chk("bub_bcnt", bcnt0, 16'd1);

    f_stat = 2'b01;
    step();
    chk("bub_fault_nofreeze", st0, 2'b01);
    chk("bub_fault_bcnt", bcnt0, 16'd2);
    stall = 1'b1; bubble = 1'b0;
    step();
    chk("stall_fault_nofreeze", st0, 2'b01);
    chk("stall_fault_scnt", scnt0, 16'd5);

    stall = 1'b0; f_opcode = 8'h00; f_rArB = 8'h34; f_valC = 64'h77; f_valP = 64'h88;
    step();
    chk("fault_stat", d0_stat, 2'b01);
    chk("fault_op", d0_opcode, 8'h00);
    chk("fault_valP", d0_valP, 64'h88);
    chk("fault_valid", d0_valid, 1'b1);
    chk("fault_state", st0, 2'b10);

    f_stat = 2'b00; f_opcode = 8'h40;
    step();
    chk("frz_load_op", d0_opcode, 8'h00);
    bubble = 1'b1;
    step();
    chk("frz_bub_op", d0_opcode, 8'h00);
    chk("frz_bub_bcnt", bcnt0, 16'd2);
    bubble = 1'b0; stall = 1'b1;
    step();
    chk("frz_stall_scnt", scnt0, 16'd5);
    chk("frz_state", st0, 2'b10);

    #2;
    rst0_n = 1'b0;
    #1;
    chk("async_rst_op", d0_opcode, 8'h10);
    chk("async_rst_stat", d0_stat, 2'b00);
    chk("async_rst_valid", d0_valid, 1'b0);
    chk("async_rst_state", st0, 2'b00);
    chk("async_rst_scnt", scnt0, 16'd0);

    step();
    stall = 1'b0; bubble = 1'b0; f_stat = 2'b00; f_opcode = 8'hA1; f_valC = 64'd9;
    rst1_n = 1'b1;
    step();
    chk("w0_first_op", d1_opcode, 8'hA1);
    chk("w0_first_valC", d1_valC, 64'd9);
    chk("w0_first_valid", d1_valid, 1'b1);
    chk("w0_state", st1, 2'b01);
    chk("u0_held_rst", d0_valid, 1'b0);

    stall = 1'b1; f_opcode = 8'hB2;
    for (int i = 0; i < 5; i++) step();
    chk("sat_scnt", scnt1, 2'd3);
    chk("sat_hold_op", d1_opcode, 8'hA1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
